// File: rtl/tcdm_cfi_initiator.sv
// Single-outstanding command-to-TCDM initiator: one CFI bus access per command,
// bounded wait for r_valid, and sticky capture of the first errored address.
`ifndef CFI_INSTR_WIDTH_DEF
`define CFI_INSTR_WIDTH_DEF 32
`endif

module tcdm_cfi_initiator #(
    parameter int DATA_W         = `CFI_INSTR_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ERR_CNT_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [31:0]          cmd_addr_i,
    input  logic                 cmd_we_i,
    input  logic [DATA_W/8-1:0]  cmd_be_i,
    input  logic [DATA_W-1:0]    cmd_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATA_W-1:0]    rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    input  logic                 err_clr_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [31:0]          err_addr_o,
    output logic                 err_valid_o,
    output logic                 master_req,
    output logic [31:0]          master_add,
    output logic                 master_wen,
    output logic [DATA_W/8-1:0]  master_be,
    output logic [DATA_W-1:0]    master_wdata,
    input  logic                 master_gnt,
    input  logic                 master_r_valid,
    input  logic [DATA_W-1:0]    master_r_rdata,
    input  logic                 master_r_opc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [15:0]          to_cnt;
    logic                 in_wait;
    logic                 to_hit;
    logic                 rsp_done;
    logic                 err_event;

    logic [31:0]          addr_p0;
    logic                 we_p0;
    logic [DATA_W/8-1:0]  be_p0;
    logic [DATA_W-1:0]    wdata_p0;

    logic [DATA_W-1:0]    rdata_p1;
    logic                 err_p1;
    logic                 to_p1;

    logic [ERR_CNT_W-1:0] err_cnt;
    logic [31:0]          err_addr;
    logic                 err_vld;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    // Timeout fires on the last allowed WAIT_R cycle; a same-cycle r_valid wins.
    assign in_wait   = (state == WAIT_R);
    assign to_hit    = in_wait && !master_r_valid && (to_cnt == TO_LAST);
    assign rsp_done  = in_wait && (master_r_valid || to_hit);
    assign err_event = in_wait && (master_r_valid ? master_r_opc : to_hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready_o = 1'b0;
        master_req  = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                master_req = 1'b1;
                if (master_gnt) begin
                    state_nxt = WAIT_R;
                end
            end
            WAIT_R: begin
                if (rsp_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: accepted command; stage p1: captured bus response
    always_ff @(posedge clk_i) begin
        if (cmd_ready_o && cmd_valid_i) begin
            addr_p0  <= cmd_addr_i;
            we_p0    <= cmd_we_i;
            be_p0    <= cmd_be_i;
            wdata_p0 <= cmd_wdata_i;
        end
        if (rsp_done) begin
            rdata_p1 <= master_r_valid ? master_r_rdata : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt <= '0;
            err_p1 <= 1'b0;
            to_p1  <= 1'b0;
        end else begin
            if (!in_wait) begin
                to_cnt <= '0;
            end else if (!master_r_valid) begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (rsp_done) begin
                err_p1 <= err_event;
                to_p1  <= to_hit;
            end
        end
    end

    // A new error in the clearing cycle survives the clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt  <= '0;
            err_addr <= '0;
            err_vld  <= 1'b0;
        end else if (err_clr_i) begin
            err_cnt  <= err_event ? ERR_CNT_W'(1) : '0;
            err_addr <= err_event ? addr_p0 : 32'h0;
            err_vld  <= err_event;
        end else if (err_event) begin
            err_cnt <= sat_inc(err_cnt);
            if (!err_vld) begin
                err_addr <= addr_p0;
                err_vld  <= 1'b1;
            end
        end
    end

    assign master_add    = (state == REQ) ? addr_p0 : 32'h0;
    assign master_wen    = (state == REQ) ? ~we_p0 : 1'b1;
    assign master_be     = (state == REQ) ? be_p0 : '0;
    assign master_wdata  = (state == REQ) ? wdata_p0 : '0;

    assign rsp_rdata_o   = (state == RESP) ? rdata_p1 : '0;
    assign rsp_err_o     = (state == RESP) && err_p1;
    assign rsp_timeout_o = (state == RESP) && to_p1;

    assign err_cnt_o     = err_cnt;
    assign err_addr_o    = err_addr;
    assign err_valid_o   = err_vld;

endmodule

// File: tb/tb_tcdm_cfi_initiator.sv
// Directed bench for tcdm_cfi_initiator: TCDM slave model, response scoreboard
// with an independent monitor, and directed timing/error/reset scenarios.
module tb_tcdm_cfi_initiator;

    localparam int DW = 32;
    localparam int TO = 8;
    localparam int EW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [31:0]   cmd_addr;
    logic [3:0]    cmd_be;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          err_clr, err_valid;
    logic [EW-1:0] err_cnt;
    logic [31:0]   err_addr;
    logic          req, wen, gnt, r_valid, r_opc;
    logic [31:0]   add;
    logic [3:0]    be;
    logic [DW-1:0] wdata, r_rdata;

    tcdm_cfi_initiator #(
        .DATA_W(DW), .TIMEOUT_CYCLES(TO), .ERR_CNT_W(EW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
        .cmd_we_i(cmd_we), .cmd_be_i(cmd_be), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .err_clr_i(err_clr), .err_cnt_o(err_cnt), .err_addr_o(err_addr), .err_valid_o(err_valid),
        .master_req(req), .master_add(add), .master_wen(wen), .master_be(be),
        .master_wdata(wdata), .master_gnt(gnt), .master_r_valid(r_valid),
        .master_r_rdata(r_rdata), .master_r_opc(r_opc)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // slave model configuration (written by the main sequence only)
    int   gnt_delay = 0;
    int   rv_delay  = 0;
    logic slv_err   = 1'b0;
    logic silent    = 1'b0;
    int   inject_req = 0;
    logic [31:0] mem [logic [31:0]];

    // slave model state (written by the slave process only)
    int          inject_seen = 0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'h0;
    logic        pend_opc = 1'b0;
    int          wcnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic e, input logic t);
        exp_q.push_back(rsp_t'{rdata: d, err: e, to: t});
    endtask

    task automatic send(input logic [31:0] a, input logic we, input logic [3:0] b, input logic [31:0] wd);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_we    = we;
        cmd_be    = b;
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        if (rsp_valid !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL rsp_wait: no rsp_valid within %0d cycles", cyc);
        end
    endtask

    task automatic run_txn(input logic [31:0] a, input logic we, input logic [3:0] b,
                           input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                           input logic et, output int lat);
        int cyc;
        expect_rsp(ed, ee, et);
        send(a, we, b, wd);
        wait_rsp(cyc);
        lat = cyc + 1;
        tick();
    endtask

    // Scoreboard monitor: checks every accepted response against the queue
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: rdata 0x%0h err %0b with no pending command", rsp_rdata, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("rsp_err", rsp_err, mon_e.err);
                chk("rsp_timeout", rsp_timeout, mon_e.to);
            end
        end
    end

    // TCDM slave: grant after gnt_delay waiting cycles, r_valid rv_delay cycles after the one following gnt
    initial begin : slave
        logic [31:0] cur;
        gnt = 1'b0; r_valid = 1'b0; r_rdata = '0; r_opc = 1'b0;
        forever begin
            @(negedge clk);
            gnt = 1'b0; r_valid = 1'b0; r_rdata = '0; r_opc = 1'b0;
            if (inject_seen != inject_req) begin
                inject_seen = inject_req;
                r_valid = 1'b1;
                r_opc   = 1'b1;
                r_rdata = 32'hDEADBEEF;
            end else if (pend) begin
                if (pend_cnt == 0) begin
                    r_valid = 1'b1;
                    r_rdata = pend_data;
                    r_opc   = pend_opc;
                    pend    = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (rst) begin
                pend = 1'b0;
                wcnt = 0;
            end else if (req) begin
                if (wcnt >= gnt_delay) begin
                    gnt  = 1'b1;
                    wcnt = 0;
                    cur  = mem.exists(add) ? mem[add] : 32'h0;
                    if (!wen) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) cur[8*b +: 8] = wdata[8*b +: 8];
                        mem[add] = cur;
                    end
                    if (!silent) begin
                        pend      = 1'b1;
                        pend_cnt  = rv_delay;
                        pend_opc  = slv_err;
                        pend_data = slv_err ? 32'hBADACCE5 : (wen ? cur : 32'h0);
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int cyc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_we = 1'b0; cmd_be = '0;
        cmd_wdata = '0; rsp_ready = 1'b1; err_clr = 1'b0;
        mem[32'h1C00_0000] = 32'h1234_5678;
        mem[32'h1C00_0004] = 32'h1122_3344;
        repeat (3) tick();

        // reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_req", req, 0);
        chk("rst_wen", wen, 1);
        chk("rst_add_be_wdata", {add, be, wdata}, 0);
        chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 0);
        chk("rst_err_regs", {err_cnt, err_addr, err_valid}, 0);
        rst = 1'b0;
        tick();

        // zero-wait read
        expect_rsp(32'h1234_5678, 1'b0, 1'b0);
        send(32'h1C00_0000, 1'b0, 4'hF, 32'h0);
        chk("read_bus", {req, add, wen}, {1'b1, 32'h1C00_0000, 1'b1});
        wait_rsp(cyc);
        chk("read_latency", cyc + 1, 3);
        tick();

        // write with gnt delayed 5 cycles: bus held for 6 cycles
        gnt_delay = 5;
        expect_rsp(32'h0, 1'b0, 1'b0);
        send(32'h1C00_0004, 1'b1, 4'b0011, 32'hAABB_CCDD);
        for (int i = 0; i < 6; i++) begin
            chk("write_bus_hold", {req, add, wen, be, wdata},
                {1'b1, 32'h1C00_0004, 1'b0, 4'b0011, 32'hAABB_CCDD});
            tick();
        end
        chk("write_req_drop", req, 0);
        wait_rsp(cyc);
        tick();
        gnt_delay = 0;
        run_txn(32'h1C00_0004, 1'b0, 4'hF, 32'h0, 32'h1122_CCDD, 1'b0, 1'b0, lat);

        // bus error response
        slv_err = 1'b1;
        run_txn(32'h1C00_0100, 1'b0, 4'hF, 32'h0, 32'hBADA_CCE5, 1'b1, 1'b0, lat);
        slv_err = 1'b0;
        chk("buserr_cnt", err_cnt, 1);
        chk("buserr_addr", {err_valid, err_addr}, {1'b1, 32'h1C00_0100});

        // silent slave: timeout after 8 WAIT_R cycles
        silent = 1'b1;
        expect_rsp(32'h0, 1'b1, 1'b1);
        send(32'h1C00_0200, 1'b0, 4'hF, 32'h0);
        wait_rsp(cyc);
        chk("timeout_latency", cyc, 9);
        tick();
        silent = 1'b0;
        chk("timeout_cnt", err_cnt, 2);
        chk("timeout_first_addr", err_addr, 32'h1C00_0100);

        // late r_valid in IDLE must be ignored
        inject_req++;
        tick();
        tick();
        chk("late_rv_idle", {cmd_ready, rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
        chk("late_rv_cnt", err_cnt, 2);

        // r_valid on the timeout cycle wins
        rv_delay = 7;
        expect_rsp(32'h1234_5678, 1'b0, 1'b0);
        send(32'h1C00_0000, 1'b0, 4'hF, 32'h0);
        wait_rsp(cyc);
        chk("rv_at_timeout_latency", cyc, 9);
        tick();
        rv_delay = 0;
        chk("rv_at_timeout_cnt", err_cnt, 2);

        // bring the count to 5
        slv_err = 1'b1;
        for (int i = 0; i < 3; i++)
            run_txn(32'h1C00_0110 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 32'hBADA_CCE5, 1'b1, 1'b0, lat);
        chk("errcnt_five", err_cnt, 5);

        // clear coincides with a new error; response stalled 10 cycles
        rsp_ready = 1'b0;
        expect_rsp(32'hBADA_CCE5, 1'b1, 1'b0);
        send(32'h1C00_0300, 1'b0, 4'hF, 32'h0);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_new_err_cnt", err_cnt, 1);
        chk("clr_new_err_addr", {err_valid, err_addr}, {1'b1, 32'h1C00_0300});
        for (int i = 0; i < 10; i++) begin
            chk("rsp_stall_stable", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready},
                {1'b1, 32'hBADA_CCE5, 1'b1, 1'b0, 1'b0});
            tick();
        end
        rsp_ready = 1'b1;
        tick();

        // counter saturates at all-ones
        for (int i = 0; i < 7; i++)
            run_txn(32'h1C00_0400 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 32'hBADA_CCE5, 1'b1, 1'b0, lat);
        slv_err = 1'b0;
        chk("errcnt_saturate", err_cnt, 7);
        chk("errcnt_sat_addr", err_addr, 32'h1C00_0300);

        // reset while req is pending: req drops without a clock edge
        gnt_delay = 10;
        send(32'h1C00_0000, 1'b0, 4'hF, 32'h0);
        chk("abort_req_before", req, 1);
        rst = 1'b1;
        #1;
        chk("abort_req_async", {req, cmd_ready}, {1'b0, 1'b1});
        tick();
        tick();
        rst = 1'b0;
        gnt_delay = 0;
        tick();

        // reset during WAIT_R: no response for the aborted command
        silent = 1'b1;
        send(32'h1C00_0000, 1'b0, 4'hF, 32'h0);
        tick();
        chk("abort_in_wait", {req, cmd_ready}, {1'b0, 1'b0});
        tick();
        rst = 1'b1;
        #1;
        chk("abort_wait_outputs", {req, cmd_ready, rsp_valid}, {1'b0, 1'b1, 1'b0});
        chk("abort_err_regs", {err_cnt, err_valid}, 0);
        tick();
        tick();
        rst = 1'b0;
        silent = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_rsp", rsp_valid, 0);
        end
        run_txn(32'h1C00_0000, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 1'b0, 1'b0, lat);
        chk("post_reset_latency", lat, 3);

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
